i2s_in: RTL and testbench

I2S_IN -- requirements
Module: i2s_in

---
 rtl/i2s_in_pkg.sv | 12 +
 rtl/i2s_in_sync2.sv | 22 ++
 rtl/i2s_in.sv | 172 +++++++++++++++++
 tb/tb_i2s_in.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/i2s_in_pkg.sv
// Audio definitions shared by the I2S transmitter and receiver: sample width
// and the lrclk level that selects each channel.
package i2s_in_pkg;

    localparam int AUDIO_DW = 16;

    typedef enum logic {
        CHAN_LEFT  = 1'b0,
        CHAN_RIGHT = 1'b1
    } chan_t;

endpackage

// File: rtl/i2s_in_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments let both flops sample their pre-edge inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_in.sv
// I2S receiver: oversamples bclk/lrclk/data on clk, assembles MSB-first words
// and presents left/right pairs once a frame stream has been acquired.
module i2s_in
    import i2s_in_pkg::*;
#(
    parameter int AUDIO_DW = i2s_in_pkg::AUDIO_DW,
    parameter int TIMEOUT  = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i2s_bclk,
    input  logic                i2s_lrclk,
    input  logic                i2s_data,
    output logic [AUDIO_DW-1:0] left_chan,
    output logic [AUDIO_DW-1:0] right_chan,
    output logic                sample_ce,
    output logic                locked,
    output logic                word_err
);

    localparam int CNT_W = $clog2(AUDIO_DW + 1);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(AUDIO_DW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUDIO_DW - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    logic bclk_s, lrclk_s, data_s;
    logic bclk_h, lrclk_h, data_h;
    logic bit_stb;

    sync2 u_sync_bclk  (.clk(clk), .rst_n(reset), .d(i2s_bclk),  .q(bclk_s));
    sync2 u_sync_lrclk (.clk(clk), .rst_n(reset), .d(i2s_lrclk), .q(lrclk_s));
    sync2 u_sync_data  (.clk(clk), .rst_n(reset), .d(i2s_data),  .q(data_s));

    // History stage; the rise strobe is registered alongside lrclk/data so the
    // capture logic sees all three from the same sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bclk_h  <= 1'b0;
            lrclk_h <= 1'b0;
            data_h  <= 1'b0;
            bit_stb <= 1'b0;
        end else begin
            bclk_h  <= bclk_s;
            lrclk_h <= lrclk_s;
            data_h  <= data_s;
            bit_stb <= bclk_s & ~bclk_h;
        end
    end

    state_t              state_q, state_d;
    chan_t               lr_prev;
    logic [CNT_W-1:0]    bitcnt;
    logic [CNT_W-1:0]    bit_pos;
    logic [AUDIO_DW-1:0] shift_q;
    logic [AUDIO_DW-1:0] word;
    logic [AUDIO_DW-1:0] left_hold;
    logic [WD_W-1:0]     wd_cnt;
    logic                room;
    logic                boundary;
    logic                word_short;
    logic                timeout;
    logic                load_left;
    logic                load_pair;
    logic                flag_err;

    // Word including the bit of the current rise; bits past AUDIO_DW are dropped.
    always_comb begin
        room       = bitcnt < CNT_FULL;
        bit_pos    = CNT_LAST - bitcnt;
        word       = shift_q;
        if (room) begin
            word = shift_q | (AUDIO_DW'(data_h) << bit_pos);
        end
        boundary   = bit_stb && (lrclk_h != lr_prev);
        word_short = bitcnt < CNT_LAST;
        timeout    = wd_cnt == WD_LIMIT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        load_left = 1'b0;
        load_pair = 1'b0;
        flag_err  = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (boundary && lr_prev == CHAN_RIGHT) begin
                    state_d = ACQUIRE;
                end
            end
            ACQUIRE, LOCKED: begin
                if (timeout) begin
                    state_d = SEARCH;
                end else if (boundary) begin
                    flag_err = word_short;
                    if (lr_prev == CHAN_LEFT) begin
                        load_left = 1'b1;
                    end else begin
                        load_pair = 1'b1;
                        state_d   = LOCKED;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lr_prev    <= CHAN_LEFT;
            bitcnt     <= '0;
            shift_q    <= '0;
            left_hold  <= '0;
            left_chan  <= '0;
            right_chan <= '0;
            sample_ce  <= 1'b0;
            word_err   <= 1'b0;
        end else begin
            sample_ce <= load_pair;
            word_err  <= flag_err;
            if (bit_stb) begin
                lr_prev <= chan_t'(lrclk_h);
                if (boundary) begin
                    shift_q <= '0;
                    bitcnt  <= '0;
                end else begin
                    shift_q <= word;
                    if (room) begin
                        bitcnt <= bitcnt + 1'b1;
                    end
                end
            end
            if (load_left) begin
                left_hold <= word;
            end
            if (load_pair) begin
                left_chan  <= left_hold;
                right_chan <= word;
            end
        end
    end

    // Saturates at the limit so a long idle period keeps reporting timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if (bit_stb) begin
            wd_cnt <= '0;
        end else if (!timeout) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_i2s_in.sv
// Self-checking bench for i2s_in: a bclk = clk/8 I2S source feeds the DUT and a
// scoreboard of expected left/right pairs is compared on every sample_ce.
module tb_i2s_in;

    localparam int DW = 16;

    typedef struct packed {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } pair_t;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          i2s_bclk  = 1'b0;
    logic          i2s_lrclk = 1'b0;
    logic          i2s_data  = 1'b0;
    logic [DW-1:0] left_chan;
    logic [DW-1:0] right_chan;
    logic          sample_ce;
    logic          locked;
    logic          word_err;

    int     total      = 0;
    int     bad        = 0;
    int     err_pulses = 0;
    int     ce_cnt     = 0;
    int     n_push     = 0;
    longint last_rise  = 0;
    logic   pending    = 1'b0;
    pair_t  sb[$];
    pair_t  mon_p;

    i2s_in #(.AUDIO_DW(DW), .TIMEOUT(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_data   (i2s_data),
        .left_chan  (left_chan),
        .right_chan (right_chan),
        .sample_ce  (sample_ce),
        .locked     (locked),
        .word_err   (word_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One bit slot: lrclk/data change with bclk low, bclk rises 4 clk later.
    task automatic send_bit(input logic lr, input logic d);
        @(negedge clk);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_data  = d;
        repeat (4) @(negedge clk);
        i2s_bclk  = 1'b1;
        last_rise = $time;
        repeat (3) @(negedge clk);
    endtask

    // Standard I2S: first slot of a word carries the previous word's LSB.
    task automatic send_word(input logic lr, input logic [31:0] w, input int width, input int nslots);
        for (int i = 0; i < nslots; i++) begin
            send_bit(lr, (i == 0) ? pending : w[width - i]);
        end
        pending = w[0];
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        sb.push_back('{l: l, r: r});
        n_push++;
    endtask

    always @(negedge clk) begin
        if (word_err) err_pulses++;
        if (sample_ce) begin
            ce_cnt++;
            if (sb.size() == 0) begin
                check("ce_count", ce_cnt, n_push);
            end else begin
                mon_p = sb.pop_front();
                check("left_chan", left_chan, mon_p.l);
                check("right_chan", right_chan, mon_p.r);
                check("ce_latency", 32'((longint'($time) - last_rise) / 10), 4);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL tb_timeout: simulation ran past its time budget");
        $fatal(1);
    end

    initial begin
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_left", left_chan, 0);
        check("rst_right", right_chan, 0);
        check("rst_ce", sample_ce, 0);
        check("rst_locked", locked, 0);
        check("rst_err", word_err, 0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // 16-bit pair after a preamble right word
        send_word(1'b1, 32'h0000, 16, 16);
        check("search_unlocked", locked, 0);
        push(16'h1234, 16'hABCD);
        send_word(1'b0, 32'h1234, 16, 16);
        send_word(1'b1, 32'hABCD, 16, 16);
        check("acquire_unlocked", locked, 0);

        // 24-bit words truncate to the top 16 bits
        push(16'h1234, 16'hFEDC);
        send_word(1'b0, 32'h123456, 24, 24);
        check("locked_after_pair", locked, 1);
        check("err_none_16", err_pulses, 0);
        send_word(1'b1, 32'hFEDCBA, 24, 24);

        // 8-bit words zero-pad and flag short words
        push(16'hA500, 16'h5A00);
        send_word(1'b0, 32'hA5, 8, 8);
        check("err_none_24", err_pulses, 0);
        send_word(1'b1, 32'h5A, 8, 8);
        check("err_short_left", err_pulses, 1);
        push(16'h0F0F, 16'hF0F0);
        send_word(1'b0, 32'h0F0F, 16, 16);
        check("err_short_right", err_pulses, 2);
        send_word(1'b1, 32'hF0F0, 16, 16);
        send_word(1'b0, 32'h8001, 16, 16);

        // bclk stops: watchdog clears 4 clk after the last rise, counts 1024,
        // and the state register drops locked one clk after that
        @(negedge clk);
        i2s_bclk = 1'b0;
        while ((longint'($time) - last_rise) < 10280) @(negedge clk);
        check("lock_hold", locked, 1);
        @(negedge clk);
        check("lock_drop", locked, 0);
        check("hold_left", left_chan, 16'h0F0F);
        check("hold_right", right_chan, 16'hF0F0);
        while ((longint'($time) - last_rise) < 11040) @(negedge clk);

        send_word(1'b1, 32'h7777, 16, 16);
        check("resume_search", locked, 0);
        push(16'h4321, 16'h8765);
        send_word(1'b0, 32'h4321, 16, 16);
        send_word(1'b1, 32'h8765, 16, 16);
        send_word(1'b0, 32'h1111, 16, 6);
        check("relocked", locked, 1);

        // reset mid-left, release mid-right
        reset = 1'b0;
        @(negedge clk);
        check("midrst_left", left_chan, 0);
        check("midrst_right", right_chan, 0);
        check("midrst_locked", locked, 0);
        send_word(1'b0, 32'h1111, 16, 10);
        send_word(1'b1, 32'h2222, 16, 5);
        reset = 1'b1;
        send_word(1'b1, 32'h2222, 16, 11);
        check("postrst_left", left_chan, 0);
        check("postrst_right", right_chan, 0);
        push(16'h3C3C, 16'hC3C3);
        send_word(1'b0, 32'h3C3C, 16, 16);
        send_word(1'b1, 32'hC3C3, 16, 16);
        check("postrst_no_ce", sb.size(), 1);
        send_word(1'b0, 32'h0000, 16, 16);

        // stream starting mid-right after an idle reset
        reset = 1'b0;
        @(negedge clk);
        i2s_bclk = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        send_word(1'b1, 32'hBEEF, 16, 7);
        push(16'h5555, 16'hAAAA);
        send_word(1'b0, 32'h5555, 16, 16);
        send_word(1'b1, 32'hAAAA, 16, 16);
        send_word(1'b0, 32'h0000, 16, 16);
        check("final_locked", locked, 1);

        repeat (20) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("ce_total", ce_cnt, n_push);
        check("err_total", err_pulses, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
